// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then releases the output-domain reset. Retries on lock timeout and gives up after MAX_RETRY.
module pll_rst_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       lock_err,
    output logic       lost_lock,
    output logic [3:0] retry_cnt
);

    localparam int unsigned CNT_W   = 20;
    localparam int unsigned RETRY_W = 4;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W:0]     STABLE_NEED = (CNT_W + 1)'(STABLE_CYCLES);
    localparam logic [CNT_W:0]     STABLE_BIAS = (CNT_W + 1)'(2);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_SAT   = '1;

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [RETRY_W-1:0]   r_retry;
    logic [RETRY_W-1:0]   w_retry_nxt;
    logic                 r_lock_meta;
    logic                 r_lock_s;
    logic                 r_pll_reset;
    logic                 r_sys_rst_n;
    logic                 r_locked;
    logic                 r_lock_err;
    logic                 r_lost_lock;
    logic                 w_pll_reset_nxt;
    logic                 w_sys_rst_n_nxt;
    logic                 w_locked_nxt;
    logic                 w_lock_err_nxt;
    logic                 w_lost_lock_nxt;
    logic                 w_stable_done;

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET_PLL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The WAIT_LOCK cycle that saw lock counts as the first of the consecutive lock cycles
    assign w_stable_done = (({1'b0, r_cnt} + STABLE_BIAS) >= STABLE_NEED);

    // Next-state logic; relock_req overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (relock_req) begin
            w_state_nxt = S_RESET_PLL;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_state_nxt = S_STABLE;
                    end else if (r_cnt == TO_LAST) begin
                        w_state_nxt = (r_retry == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
                    end
                end
                S_STABLE: begin
                    if (!r_lock_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end else if (w_stable_done) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) begin
                        w_state_nxt = S_RESET_PLL;
                    end
                end
                S_FAIL: begin
                    w_state_nxt = S_FAIL;
                end
                default: begin
                    w_state_nxt = S_RESET_PLL;
                end
            endcase
        end
    end

    // Output/datapath decode from the next state so everything moves on the state edge
    always_comb begin
        w_cnt_nxt       = '0;
        w_retry_nxt     = r_retry;
        w_lost_lock_nxt = 1'b0;

        if (!relock_req && (w_state_nxt == r_state) &&
            (r_state != S_RUN) && (r_state != S_FAIL)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        if (relock_req) begin
            w_retry_nxt = '0;
        end else if ((r_state == S_WAIT_LOCK) && (w_state_nxt == S_RESET_PLL)) begin
            w_retry_nxt = (r_retry == RETRY_SAT) ? r_retry : r_retry + RETRY_W'(1);
        end else if ((w_state_nxt == S_RUN) || (r_state == S_RUN)) begin
            w_retry_nxt = '0;
        end

        if (!relock_req && (r_state == S_RUN) && (w_state_nxt == S_RESET_PLL)) begin
            w_lost_lock_nxt = 1'b1;
        end

        w_pll_reset_nxt = (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAIL);
        w_sys_rst_n_nxt = (w_state_nxt == S_RUN);
        w_locked_nxt    = (w_state_nxt == S_RUN);
        w_lock_err_nxt  = (w_state_nxt == S_FAIL);
    end

    // Counter, retry count and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_err  <= 1'b0;
            r_lost_lock <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_reset <= w_pll_reset_nxt;
            r_sys_rst_n <= w_sys_rst_n_nxt;
            r_locked    <= w_locked_nxt;
            r_lock_err  <= w_lock_err_nxt;
            r_lost_lock <= w_lost_lock_nxt;
        end
    end

    assign pll_reset = r_pll_reset;
    assign sys_rst_n = r_sys_rst_n;
    assign locked    = r_locked;
    assign lock_err  = r_lock_err;
    assign lost_lock = r_lost_lock;
    assign retry_cnt = r_retry;

endmodule
